// File: rtl/fifo_pkg.sv
// Shared types and parameter legality check for the parametrised synchronous FIFO.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    NORMAL = 2'd1,
    FULL   = 2'd2
  } fifo_state_t;

  // Depth must be a power of two (>=4) so pointers wrap for free; thresholds must lie inside 0..depth.
  function automatic bit fifo_params_ok(input int depth, input int af, input int ae);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one-hot write decode into DEPTH x DATA_W registers, combinational read mux.
module fifo_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DEPTH-1:0]  w_en;
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_comb begin
    w_en            = '0;
    w_en[i_wr_addr] = i_wr_en;
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk) begin
      if (w_en[g]) r_mem[g] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO: pointers, occupancy, status FSM, flags, sticky errors.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ack,
  output logic              wr_ack,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   data_count,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam bit PARAMS_OK = fifo_params_ok(DEPTH, AF_LEVEL, AE_LEVEL);
  if (!PARAMS_OK) begin : g_bad_params
    $error("param_sync_fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_AF    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   CNT_AE    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  fifo_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic [DATA_W-1:0] w_mem_rd, r_rd_data;
  logic              w_wr_acc, w_rd_acc;
  logic              r_wr_ack, r_rd_ack, r_af, r_ae, r_ovf, r_udf;

  // When full, a simultaneous read frees the slot the write lands in.
  assign w_wr_acc = wr_en && !clear && (!full || rd_en);
  assign w_rd_acc = rd_en && !clear && !empty;

  fifo_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_regfile (
    .clk       (clk),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rd)
  );

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + CNT_ONE;
    else if (w_rd_acc && !w_wr_acc) w_count_nxt = r_count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY:  if (w_wr_acc) w_state_nxt = NORMAL;
        NORMAL: begin
          if (w_wr_acc && !w_rd_acc && (w_count_nxt == CNT_DEPTH))  w_state_nxt = FULL;
          else if (w_rd_acc && !w_wr_acc && (w_count_nxt == '0))     w_state_nxt = EMPTY;
        end
        FULL:   if (w_rd_acc && !w_wr_acc) w_state_nxt = NORMAL;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    full  = (r_state == FULL);
    empty = (r_state == EMPTY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_wr_ack  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_af      <= 1'b0;
      r_ae      <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else if (clear) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_wr_ack  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_af      <= 1'b0;
      r_ae      <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_rd_data <= w_mem_rd;
      end
      r_count  <= w_count_nxt;
      r_wr_ack <= w_wr_acc;
      r_rd_ack <= w_rd_acc;
      // Flags follow the next count so they line up with data_count.
      r_af     <= (w_count_nxt >= CNT_AF);
      r_ae     <= (w_count_nxt <= CNT_AE);
      if (wr_en && full && !rd_en) r_ovf <= 1'b1;
      if (rd_en && empty)          r_udf <= 1'b1;
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_ack       = r_rd_ack;
  assign wr_ack       = r_wr_ack;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign data_count   = r_count;
  assign ovf_err      = r_ovf;
  assign udf_err      = r_udf;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at DATA_W=32, DEPTH=8.
module tb_param_sync_fifo;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_ack;
  logic        wr_ack;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  data_count;
  logic        ovf_err;
  logic        udf_err;

  int n_cmp;
  int n_mis;

  param_sync_fifo #(.DATA_W(32), .DEPTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_ack       (rd_ack),
    .wr_ack       (wr_ack),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_count   (data_count),
    .ovf_err      (ovf_err),
    .udf_err      (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs are then changed for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    reset_n = 1'b0;
    clear   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    rd_en   = 1'b0;

    // Reset held 3 cycles with a write request pending.
    repeat (3) step();
    check("rst_empty",  empty,        1);
    check("rst_count",  data_count,   0);
    check("rst_rddata", rd_data,      0);
    check("rst_wrack",  wr_ack,       0);
    check("rst_ae",     almost_empty, 1);
    check("rst_full",   full,         0);
    wr_en   = 1'b0;
    reset_n = 1'b1;
    step();

    // Fill 0x11..0x88.
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'(8'h11 * (i + 1));
      step();
      check("fill_count", data_count,   i + 1);
      check("fill_wrack", wr_ack,       1);
      check("fill_af",    almost_full,  (i + 1) >= 6);
      check("fill_ae",    almost_empty, (i + 1) <= 2);
      check("fill_full",  full,         (i == 7));
    end
    wr_data = 32'h99;
    step();
    check("ovf_err",   ovf_err,    1);
    check("ovf_count", data_count, 8);
    check("ovf_wrack", wr_ack,     0);
    check("ovf_full",  full,       1);
    wr_en = 1'b0;

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      step();
      check("drain_ack",  rd_ack,  1);
      check("drain_data", rd_data, 32'(8'h11 * (i + 1)));
    end
    rd_en = 1'b0;
    step();
    check("drain_empty", empty,      1);
    check("drain_count", data_count, 0);
    rd_en = 1'b1;
    step();
    check("udf_err",   udf_err, 1);
    check("udf_ack",   rd_ack,  0);
    check("udf_hold",  rd_data, 32'h88);
    rd_en = 1'b0;

    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr1_ovf", ovf_err, 0);
    check("clr1_udf", udf_err, 0);

    // Wrap: 4 rounds of 5 writes then 5 reads, data = running index.
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 5; j++) begin
        wr_en   = 1'b1;
        wr_data = 32'(r * 5 + j);
        step();
      end
      wr_en = 1'b0;
      check("wrap_count", data_count, 5);
      for (int j = 0; j < 5; j++) begin
        rd_en = 1'b1;
        step();
        check("wrap_data", rd_data, 32'(r * 5 + j));
      end
      rd_en = 1'b0;
    end
    check("wrap_empty", empty,   1);
    check("wrap_ovf",   ovf_err, 0);
    check("wrap_udf",   udf_err, 0);

    // Full with simultaneous read and write.
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'(8'h10 + i);
      step();
    end
    check("fb_full0", full, 1);
    rd_en   = 1'b1;
    wr_data = 32'hAA;
    step();
    wr_en = 1'b0;
    check("fb_rddata", rd_data,    32'h10);
    check("fb_rdack",  rd_ack,     1);
    check("fb_wrack",  wr_ack,     1);
    check("fb_count",  data_count, 8);
    check("fb_full",   full,       1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("fb_drain", rd_data, (i == 7) ? 32'hAA : 32'(8'h11 + i));
    end
    rd_en = 1'b0;
    check("fb_empty", empty, 1);

    // Empty with both requests: write taken, read rejected.
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 32'h33;
    step();
    rd_en = 1'b0;
    check("ewr_count", data_count, 1);
    check("ewr_rdack", rd_ack,     0);
    check("ewr_wrack", wr_ack,     1);
    check("ewr_udf",   udf_err,    1);
    check("ewr_hold",  rd_data,    32'hAA);
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'(8'h40 + i);
      step();
    end
    check("pre_clr_count", data_count, 5);

    // Clear with a write pending.
    clear   = 1'b1;
    wr_data = 32'h77;
    step();
    clear = 1'b0;
    wr_en = 1'b0;
    check("clr_count", data_count,   0);
    check("clr_empty", empty,        1);
    check("clr_udf",   udf_err,      0);
    check("clr_ovf",   ovf_err,      0);
    check("clr_wrack", wr_ack,       0);
    check("clr_ae",    almost_empty, 1);

    wr_en   = 1'b1;
    wr_data = 32'h5A;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("post_clr_data", rd_data, 32'h5A);
    check("post_clr_ack",  rd_ack,  1);
    check("post_clr_empty", empty,  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
